// File: rtl/mont_mul_iter_if.sv
// ---------------------------------------------------------------------------
// mont_mul_iter_if
// Purpose : groups the control handshake and operand/result bus of the
//           bit-serial Montgomery multiplier into one bundle.
// Signals : ena    - clock enable from the sequencing FSM
//           start  - request a new multiplication
//           A, B   - multiplier / multiplicand operands
//           M      - odd modulus
//           busy   - multiplier is iterating or doing the final subtract
//           done   - one-enabled-cycle completion pulse
//           result - last fully reduced product A*B*2^-WIDTH mod M
// Modports: master drives the request side, slave is the multiplier.
// ---------------------------------------------------------------------------
interface mont_mul_iter_if #(
  parameter int WIDTH = 4
);
  logic             ena;
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] M;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output ena, start, A, B, M,
    input  busy, done, result
  );

  modport slave (
    input  ena, start, A, B, M,
    output busy, done, result
  );
endinterface

// File: rtl/mont_mul_iter.sv
// ---------------------------------------------------------------------------
// mont_mul_iter
// Purpose : bit-serial Montgomery modular multiplier computing
//           P = A*B*2^-WIDTH mod M, consuming one bit of A per enabled cycle,
//           followed by one conditional subtraction for a fully reduced result.
// Ports   : clk  - rising-edge clock
//           rst  - synchronous active-high reset, overrides ena
//           bus  - mont_mul_iter_if slave: ena, start, A, B, M in;
//                  busy, done, result out
// Timing  : start accepted at enabled edge k -> done high after enabled
//           edge k+WIDTH+1, with result valid in the same cycle.
// ---------------------------------------------------------------------------
module mont_mul_iter #(
  parameter int WIDTH = 4
) (
  input logic          clk,
  input logic          rst,
  mont_mul_iter_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SUB  = 2'd2
  } state_t;

  state_t           state_q, state_n;
  logic [WIDTH:0]   r_q, r_n;
  logic [WIDTH-1:0] a_sh_q, a_sh_n;
  logic [WIDTH-1:0] b_q, b_n;
  logic [WIDTH-1:0] m_q, m_n;
  logic [CW-1:0]    count_q, count_n;
  logic [WIDTH-1:0] result_q, result_n;
  logic             done_q, done_n;

  // One Montgomery step. Two extra bits cover R + B + M < 4M, and the
  // conditional add of M makes the sum even so the halving is exact.
  logic [WIDTH+1:0] s_add;
  logic [WIDTH+1:0] s_red;
  logic [WIDTH:0]   r_step;
  logic [WIDTH-1:0] r_reduced;

  always_comb begin
    s_add     = {1'b0, r_q} + {2'b00, (a_sh_q[0] ? b_q : {WIDTH{1'b0}})};
    s_red     = s_add[0] ? (s_add + {2'b00, m_q}) : s_add;
    r_step    = (WIDTH+1)'(s_red >> 1);
    r_reduced = WIDTH'((r_q >= {1'b0, m_q}) ? (r_q - {1'b0, m_q}) : r_q);
  end

  // Next-state and datapath control; every register holds by default.
  always_comb begin
    state_n  = state_q;
    r_n      = r_q;
    a_sh_n   = a_sh_q;
    b_n      = b_q;
    m_n      = m_q;
    count_n  = count_q;
    result_n = result_q;
    done_n   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_sh_n  = bus.A;
          b_n     = bus.B;
          m_n     = bus.M;
          r_n     = '0;
          count_n = '0;
          state_n = RUN;
        end
      end
      RUN: begin
        r_n     = r_step;
        a_sh_n  = a_sh_q >> 1;
        count_n = count_q + CW'(1);
        if (count_q == CW'(WIDTH - 1)) begin
          state_n = SUB;
        end
      end
      SUB: begin
        result_n = r_reduced;
        done_n   = 1'b1;
        state_n  = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State register; ena freezes everything, including a pending done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      r_q      <= '0;
      a_sh_q   <= '0;
      b_q      <= '0;
      m_q      <= '0;
      count_q  <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else if (bus.ena) begin
      state_q  <= state_n;
      r_q      <= r_n;
      a_sh_q   <= a_sh_n;
      b_q      <= b_n;
      m_q      <= m_n;
      count_q  <= count_n;
      result_q <= result_n;
      done_q   <= done_n;
    end
  end

  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_mont_mul_iter.sv
// ---------------------------------------------------------------------------
// tb_mont_mul_iter
// Purpose : directed self-checking bench for mont_mul_iter at WIDTH=4.
//           Expected products are hand-computed A*B*16^-1 mod M values.
// ---------------------------------------------------------------------------
module tb_mont_mul_iter;

  localparam int WIDTH = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mont_mul_iter_if #(.WIDTH(WIDTH)) bus ();

  mont_mul_iter #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int a, input int b, input int m);
    bus.A     = WIDTH'(a);
    bus.B     = WIDTH'(b);
    bus.M     = WIDTH'(m);
    bus.start = 1'b1;
    bus.ena   = 1'b1;
  endtask

  // Start is already presented; run one full multiplication with ena=1
  // and check busy/done on every edge plus the final result.
  task automatic runToDone(input string tag, input int expected, input bit poke);
    tick();
    bus.start = 1'b0;
    checkOutput({tag, "_accept_busy"}, int'(bus.busy), 1);
    checkOutput({tag, "_accept_done"}, int'(bus.done), 0);
    for (int i = 1; i < WIDTH + 1; i++) begin
      if (poke && i == 2) begin
        bus.start = 1'b1;
        bus.A     = 4'd3;
        bus.B     = 4'd3;
        bus.M     = 4'd5;
      end
      tick();
      checkOutput({tag, "_run_busy"}, int'(bus.busy), 1);
      checkOutput({tag, "_run_done"}, int'(bus.done), 0);
    end
    bus.start = 1'b0;
    tick();
    checkOutput({tag, "_done"}, int'(bus.done), 1);
    checkOutput({tag, "_done_busy"}, int'(bus.busy), 0);
    checkOutput({tag, "_result"}, int'(bus.result), expected);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    bus.ena   = 1'b1;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    bus.M     = '0;

    // Reset and idle state
    tick();
    tick();
    rst = 1'b0;
    checkOutput("reset_busy", int'(bus.busy), 0);
    checkOutput("reset_done", int'(bus.done), 0);
    checkOutput("reset_result", int'(bus.result), 0);

    // start with ena=0 must be ignored
    applyStimulus(7, 5, 13);
    bus.ena = 1'b0;
    tick();
    checkOutput("noena_busy", int'(bus.busy), 0);
    bus.start = 1'b0;
    bus.ena   = 1'b1;
    tick();
    checkOutput("noena_idle_busy", int'(bus.busy), 0);
    checkOutput("noena_idle_done", int'(bus.done), 0);

    // 7*5*16^-1 mod 13 = 3, no final subtraction
    applyStimulus(7, 5, 13);
    runToDone("mul_7_5_13", 3, 1'b0);
    tick();
    checkOutput("pulse_clear_done", int'(bus.done), 0);
    checkOutput("result_hold", int'(bus.result), 3);

    // 14*14*16^-1 mod 15 = 1 via R=16 -> 16-15; a stray start mid-run is ignored
    applyStimulus(14, 14, 15);
    runToDone("mul_14_14_15", 1, 1'b1);

    // 0*9 mod 11 = 0, then back-to-back start in the done cycle: 12*12 mod 13 -> 9
    tick();
    applyStimulus(0, 9, 11);
    runToDone("mul_0_9_11", 0, 1'b0);
    applyStimulus(12, 12, 13);
    runToDone("b2b_12_12_13", 9, 1'b0);

    // ena toggling every cycle: done after 5 enabled edges, holds while ena=0
    tick();
    applyStimulus(7, 5, 13);
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      bus.ena = 1'b0;
      tick();
      checkOutput("toggle_hold_busy", int'(bus.busy), 1);
      checkOutput("toggle_hold_result", int'(bus.result), 9);
      bus.ena = 1'b1;
      tick();
      checkOutput("toggle_run_done", int'(bus.done), 0);
    end
    bus.ena = 1'b0;
    tick();
    checkOutput("toggle_pre_sub_busy", int'(bus.busy), 1);
    bus.ena = 1'b1;
    tick();
    checkOutput("toggle_done", int'(bus.done), 1);
    checkOutput("toggle_result", int'(bus.result), 3);
    bus.ena = 1'b0;
    tick();
    tick();
    checkOutput("toggle_done_held", int'(bus.done), 1);
    checkOutput("toggle_result_held", int'(bus.result), 3);
    bus.ena = 1'b1;
    tick();
    checkOutput("toggle_done_clear", int'(bus.done), 0);

    // Reset in the middle of a run after two iterations
    applyStimulus(14, 14, 15);
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midrst_busy", int'(bus.busy), 0);
    checkOutput("midrst_done", int'(bus.done), 0);
    checkOutput("midrst_result", int'(bus.result), 0);
    for (int i = 0; i < WIDTH + 2; i++) begin
      tick();
      checkOutput("midrst_no_done", int'(bus.done), 0);
    end
    applyStimulus(7, 5, 13);
    runToDone("post_rst_7_5_13", 3, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
